a_rd_ctrl_x2_ram: RTL and testbench

Ping-pong read controller for a pair of 16-bit RAM banks. It sits directly upstream of the two-input read crossbar.
- Issues sequential read enables and addresses to the bank currently owned by the read side.
- Drives the crossbar select delayed by the RAM read latency, so the select matches each returning `dv`/data word.
- Hands each bank back to the write side once its last word has left the RAM.

---
 rtl/a_rd_ctrl_x2_ram.sv | 118 +++++++++++
 tb/tb_a_rd_ctrl_x2_ram.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/a_rd_ctrl_x2_ram.sv
// Ping-pong read controller for two RAM banks; crossbar select delayed by RD_LAT.
// Optional sticky protocol check: define A_RD_CTRL_X2_RAM_ERR_CHECK_EN.
module a_rd_ctrl_x2_ram #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        bank_full_i,
  input  logic              ready_i,
  output logic              rd_en_o_0,
  output logic              rd_en_o_1,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              ctrl_o,
  output logic [1:0]        bank_free_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t              state;
  logic                cur;
  logic [ADDR_W-1:0]   addr;
  logic                sel;
  logic [RD_LAT-1:0]   sel_pipe;
  logic [RD_LAT-1:0]   vld_pipe;
  logic [1:0]          free_pipe [RD_LAT];

  logic                issue;
  logic                last;
  logic                sel_d;
  logic [1:0]          free_d;

  assign issue  = (state == READ) && ready_i;
  assign last   = issue && (addr == LAST);
  assign sel_d  = issue ? cur : sel;
  assign free_d = last ? (cur ? 2'b10 : 2'b01) : 2'b00;

  assign rd_en_o_0   = issue && !cur;
  assign rd_en_o_1   = issue && cur;
  assign rd_addr_o   = addr;
  assign ctrl_o      = sel_pipe[RD_LAT-1];
  assign bank_free_o = free_pipe[RD_LAT-1];
  assign busy_o      = (state == READ) || (|vld_pipe);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cur   <= 1'b0;
      addr  <= '0;
      sel   <= 1'b0;
    end else begin
      sel <= sel_d;
      unique case (state)
        IDLE: begin
          if (bank_full_i[cur])
            state <= READ;
        end
        READ: begin
          if (issue)
            addr <= addr + 1'b1;
          if (last) begin
            cur <= ~cur;
            if (!bank_full_i[~cur])
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0 takes the next-sel value so ctrl_o lines up with dv at t+RD_LAT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_pipe <= '0;
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++)
        free_pipe[i] <= 2'b00;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        sel_pipe[i]  <= sel_pipe[i-1];
        vld_pipe[i]  <= vld_pipe[i-1];
        free_pipe[i] <= free_pipe[i-1];
      end
      sel_pipe[0]  <= sel_d;
      vld_pipe[0]  <= issue;
      free_pipe[0] <= free_d;
    end
  end

`ifdef A_RD_CTRL_X2_RAM_ERR_CHECK_EN
  logic err_q;
  logic early_drop;
  logic free_drop;

  assign early_drop = (state == READ) && !last && !bank_full_i[cur];
  assign free_drop  = |(bank_free_o & ~bank_full_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      err_q <= 1'b0;
    else if (early_drop || free_drop)
      err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_a_rd_ctrl_x2_ram.sv
// Directed vector bench for a_rd_ctrl_x2_ram (ADDR_W=2, RD_LAT=2).
// Table of per-cycle inputs/expected outputs plus reset and error sequences.
module tb_a_rd_ctrl_x2_ram;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [1:0] bank_full_i = 2'b00;
  logic       ready_i = 1'b1;
  logic       rd_en_o_0;
  logic       rd_en_o_1;
  logic [1:0] rd_addr_o;
  logic       ctrl_o;
  logic [1:0] bank_free_o;
  logic       busy_o;
  logic       err_o;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  a_rd_ctrl_x2_ram #(.ADDR_W(2), .RD_LAT(2)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .bank_full_i (bank_full_i),
    .ready_i     (ready_i),
    .rd_en_o_0   (rd_en_o_0),
    .rd_en_o_1   (rd_en_o_1),
    .rd_addr_o   (rd_addr_o),
    .ctrl_o      (ctrl_o),
    .bank_free_o (bank_free_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic       rst;
    logic [1:0] full;
    logic       rdy;
    logic       en0;
    logic       en1;
    logic [1:0] addr;
    logic       ctrl;
    logic [1:0] free;
    logic       busy;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic [1:0] full,
                     input logic rdy, input logic en0, input logic en1,
                     input logic [1:0] addr, input logic ctrl,
                     input logic [1:0] free, input logic busy);
    vec_t v;
    v.rst = rst; v.full = full; v.rdy = rdy;
    v.en0 = en0; v.en1 = en1; v.addr = addr;
    v.ctrl = ctrl; v.free = free; v.busy = busy;
    tv.push_back(v);
  endtask

  // out order: en0 en1 addr ctrl free busy err
  task automatic chk(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {rd_en_o_0, rd_en_o_1, rd_addr_o, ctrl_o,
           bank_free_o, busy_o, err_o};
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got en0/en1/addr/ctrl/free/busy/err=%b expected %b",
               name, got, exp);
    end
  endtask

  initial begin
    // reset, then single bank 0
    add(0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b01, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b01, 1, 1, 0, 0, 0, 2'b00, 1);
    add(1, 2'b01, 1, 1, 0, 1, 0, 2'b00, 1);
    add(1, 2'b01, 1, 1, 0, 2, 0, 2'b00, 1);
    add(1, 2'b01, 1, 1, 0, 3, 0, 2'b00, 1);
    add(1, 2'b01, 1, 0, 0, 0, 0, 2'b00, 1);
    add(1, 2'b01, 1, 0, 0, 0, 0, 2'b01, 1);
    add(1, 2'b01, 1, 0, 0, 0, 0, 2'b00, 0);
    // back-to-back banks
    add(0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b11, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b11, 1, 1, 0, 0, 0, 2'b00, 1);
    add(1, 2'b11, 1, 1, 0, 1, 0, 2'b00, 1);
    add(1, 2'b11, 1, 1, 0, 2, 0, 2'b00, 1);
    add(1, 2'b11, 1, 1, 0, 3, 0, 2'b00, 1);
    add(1, 2'b11, 1, 0, 1, 0, 0, 2'b00, 1);
    add(1, 2'b11, 1, 0, 1, 1, 0, 2'b01, 1);
    add(1, 2'b11, 1, 0, 1, 2, 1, 2'b00, 1);
    add(1, 2'b10, 1, 0, 1, 3, 1, 2'b00, 1);
    add(1, 2'b10, 1, 0, 0, 0, 1, 2'b00, 1);
    add(1, 2'b10, 1, 0, 0, 0, 1, 2'b10, 1);
    add(1, 2'b10, 1, 0, 0, 0, 1, 2'b00, 0);
    // backpressure on bank 0
    add(1, 2'b01, 1, 0, 0, 0, 1, 2'b00, 0);
    add(1, 2'b01, 1, 1, 0, 0, 1, 2'b00, 1);
    add(1, 2'b01, 1, 1, 0, 1, 1, 2'b00, 1);
    add(1, 2'b01, 0, 0, 0, 2, 0, 2'b00, 1);
    add(1, 2'b01, 0, 0, 0, 2, 0, 2'b00, 1);
    add(1, 2'b01, 0, 0, 0, 2, 0, 2'b00, 1);
    add(1, 2'b01, 1, 1, 0, 2, 0, 2'b00, 1);
    add(1, 2'b01, 1, 1, 0, 3, 0, 2'b00, 1);
    add(1, 2'b01, 1, 0, 0, 0, 0, 2'b00, 1);
    add(1, 2'b01, 1, 0, 0, 0, 0, 2'b01, 1);
    add(1, 2'b01, 1, 0, 0, 0, 0, 2'b00, 0);
    // late bank 1
    add(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b10, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 2'b10, 1, 0, 1, 0, 0, 2'b00, 1);
    add(1, 2'b10, 1, 0, 1, 1, 0, 2'b00, 1);
    add(1, 2'b10, 1, 0, 1, 2, 1, 2'b00, 1);
    add(1, 2'b10, 1, 0, 1, 3, 1, 2'b00, 1);
    add(1, 2'b10, 1, 0, 0, 0, 1, 2'b00, 1);
    add(1, 2'b10, 1, 0, 0, 0, 1, 2'b10, 1);
    add(1, 2'b00, 1, 0, 0, 0, 1, 2'b00, 0);

    foreach (tv[i]) begin
      @(negedge clk_i);
      rst_n_i = tv[i].rst;
      bank_full_i = tv[i].full;
      ready_i = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          {tv[i].en0, tv[i].en1, tv[i].addr, tv[i].ctrl,
           tv[i].free, tv[i].busy, 1'b0});
    end

    // mid-frame async reset abandons in-flight reads
    @(negedge clk_i);
    bank_full_i = 2'b01;
    @(negedge clk_i);
    #1 chk("rst_pre", 9'b1_0_00_1_00_1_0);
    @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1 chk("rst_async", 9'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    bank_full_i = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      #1 chk($sformatf("rst_quiet%0d", k), 9'b0);
    end
    bank_full_i = 2'b01;
    @(negedge clk_i);
    #1 chk("rst_restart", 9'b1_0_00_0_00_1_0);

`ifdef A_RD_CTRL_X2_RAM_ERR_CHECK_EN
    @(negedge clk_i);
    #1 chk("err_a1", 9'b1_0_01_0_00_1_0);
    bank_full_i = 2'b00;
    @(negedge clk_i);
    #1 chk("err_a2", 9'b1_0_10_0_00_1_1);
    @(negedge clk_i);
    #1 chk("err_a3", 9'b1_0_11_0_00_1_1);
    @(negedge clk_i);
    #1 chk("err_sticky", 9'b0_0_00_0_00_1_1);
`endif

    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1 chk("final_rst", 9'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
